alu_sequencer: RTL and testbench

Multi-cycle control unit that sequences the 8-bit ALU and the register file for one instruction at a time. It accepts a 32-bit instruction through a valid/ready handshake, decodes it, and drives ALUOP, the register addresses and the operand mux selects. It holds those controls stable for the ALU's settle time, then issues a single-cycle register write. It sits between the instruction source and the ALU/register-file datapath.

---
 rtl/alu_sequencer.sv | 171 +++++++++++++++++
 tb/tb_alu_sequencer.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/alu_sequencer.sv
// alu_sequencer: multi-cycle control unit for the 8-bit ALU and the register file.
// Accepts one 32-bit instruction at a time over a valid/ready handshake and decodes it.
// Holds ALUOP, the register addresses and the operand selects steady while the ALU settles,
// then issues a single-cycle register write.
//
// Ports:
//   CLK          clock, rising edge
//   RESET        asynchronous, active-high reset
//   INSTRUCTION  OP[31:24], DEST[23:16], SRC1[15:8], SRC2/IMM[7:0]
//   INSTR_VALID  INSTRUCTION is valid
//   INSTR_READY  sequencer can accept an instruction (IDLE and not in reset)
//   READREG1     register-file read address 1 (SRC1[2:0])
//   READREG2     register-file read address 2 (SRC2[2:0])
//   WRITEREG     register-file write address (DEST[2:0])
//   WRITEENABLE  register-file write strobe, one cycle per legal instruction
//   ALUOP        ALU select code
//   IMMEDIATE    IMM field
//   IMM_SEL      ALU DATA2 comes from IMMEDIATE
//   NEG_SEL      ALU DATA2 is the negated register operand
//   BUSY         sequencer is not idle
//   ILLEGAL      one-cycle pulse while an undefined opcode sits in DECODE
module alu_sequencer #(
  parameter int unsigned ADD_WAIT   = 2,
  parameter int unsigned LOGIC_WAIT = 1
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [31:0] INSTRUCTION,
  input  logic        INSTR_VALID,
  output logic        INSTR_READY,
  output logic [2:0]  READREG1,
  output logic [2:0]  READREG2,
  output logic [2:0]  WRITEREG,
  output logic        WRITEENABLE,
  output logic [2:0]  ALUOP,
  output logic [7:0]  IMMEDIATE,
  output logic        IMM_SEL,
  output logic        NEG_SEL,
  output logic        BUSY,
  output logic        ILLEGAL
);

  typedef enum logic [1:0] {StIdle, StDecode, StExec, StWrite} state_e;

  localparam logic [3:0] AddLoad   = 4'(ADD_WAIT);
  localparam logic [3:0] LogicLoad = 4'(LOGIC_WAIT);

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;

  logic [2:0]  readreg1_q, readreg2_q, writereg_q, aluop_q;
  logic [7:0]  imm_q;
  logic        imm_sel_q, neg_sel_q;
  logic        is_add_q, illegal_q;

  // Combinational decode of the incoming word; only used at the accept edge.
  logic        dec_legal, dec_add, dec_imm_sel, dec_neg_sel;
  logic [2:0]  dec_aluop;
  logic        accept;

  // Upper register-field bits are ignored by design.
  logic        unused_reg_bits;
  assign unused_reg_bits = ^{INSTRUCTION[23:19], INSTRUCTION[15:11]};

  assign accept = (state_q == StIdle) && INSTR_VALID;

  always_comb begin
    dec_legal   = 1'b1;
    dec_add     = 1'b0;
    dec_imm_sel = 1'b0;
    dec_neg_sel = 1'b0;
    dec_aluop   = 3'b000;
    unique case (INSTRUCTION[31:24])
      8'h00: dec_imm_sel = 1'b1;
      8'h01: dec_aluop   = 3'b000;
      8'h02: begin
        dec_aluop = 3'b001;
        dec_add   = 1'b1;
      end
      8'h03: begin
        dec_aluop   = 3'b001;
        dec_add     = 1'b1;
        dec_neg_sel = 1'b1;
      end
      8'h04: dec_aluop = 3'b010;
      8'h05: dec_aluop = 3'b011;
      default: dec_legal = 1'b0;
    endcase
  end

  // Controls are captured at the accept edge so they are already valid during DECODE.
  // An illegal opcode leaves the previous controls in place.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      readreg1_q <= 3'b000;
      readreg2_q <= 3'b000;
      writereg_q <= 3'b000;
      aluop_q    <= 3'b000;
      imm_q      <= 8'h00;
      imm_sel_q  <= 1'b0;
      neg_sel_q  <= 1'b0;
      is_add_q   <= 1'b0;
      illegal_q  <= 1'b0;
    end else if (accept) begin
      illegal_q <= ~dec_legal;
      is_add_q  <= dec_add;
      if (dec_legal) begin
        readreg1_q <= INSTRUCTION[10:8];
        readreg2_q <= INSTRUCTION[2:0];
        writereg_q <= INSTRUCTION[18:16];
        aluop_q    <= dec_aluop;
        imm_q      <= INSTRUCTION[7:0];
        imm_sel_q  <= dec_imm_sel;
        neg_sel_q  <= dec_neg_sel;
      end
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= StIdle;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (INSTR_VALID) state_d = StDecode;
      end
      StDecode: begin
        if (illegal_q) begin
          state_d = StIdle;
        end else begin
          // EXEC runs from the load value down to zero inclusive, so the write
          // strobe lands W+2 edges after DECODE begins.
          cnt_d   = is_add_q ? AddLoad : LogicLoad;
          state_d = StExec;
        end
      end
      StExec: begin
        if (cnt_q == 4'd0) begin
          state_d = StWrite;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StWrite: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  assign INSTR_READY = (state_q == StIdle) && !RESET;
  assign BUSY        = (state_q != StIdle);
  assign WRITEENABLE = (state_q == StWrite);
  assign ILLEGAL     = (state_q == StDecode) && illegal_q;

  assign READREG1  = readreg1_q;
  assign READREG2  = readreg2_q;
  assign WRITEREG  = writereg_q;
  assign ALUOP     = aluop_q;
  assign IMMEDIATE = imm_q;
  assign IMM_SEL   = imm_sel_q;
  assign NEG_SEL   = neg_sel_q;

endmodule

// File: tb/tb_alu_sequencer.sv
module tb_alu_sequencer;

  localparam int AddW   = 2;
  localparam int LogicW = 1;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic [31:0] INSTRUCTION = 32'h0;
  logic        INSTR_VALID = 1'b0;
  logic        INSTR_READY;
  logic [2:0]  READREG1, READREG2, WRITEREG, ALUOP;
  logic        WRITEENABLE, IMM_SEL, NEG_SEL, BUSY, ILLEGAL;
  logic [7:0]  IMMEDIATE;

  always #5 CLK = ~CLK;

  alu_sequencer #(
    .ADD_WAIT   (AddW),
    .LOGIC_WAIT (LogicW)
  ) dut (
    .CLK         (CLK),
    .RESET       (RESET),
    .INSTRUCTION (INSTRUCTION),
    .INSTR_VALID (INSTR_VALID),
    .INSTR_READY (INSTR_READY),
    .READREG1    (READREG1),
    .READREG2    (READREG2),
    .WRITEREG    (WRITEREG),
    .WRITEENABLE (WRITEENABLE),
    .ALUOP       (ALUOP),
    .IMMEDIATE   (IMMEDIATE),
    .IMM_SEL     (IMM_SEL),
    .NEG_SEL     (NEG_SEL),
    .BUSY        (BUSY),
    .ILLEGAL     (ILLEGAL)
  );

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s @%0t got=%0h exp=%0h", tag, $time, got, exp);
    end
  endtask

  // Transaction-level reference: ph counts cycles since acceptance (-1 when idle),
  // len is the total number of busy cycles of the current instruction.
  int         ph;
  int         len;
  logic       m_illegal;
  logic [2:0] m_r1, m_r2, m_wr, m_op;
  logic [7:0] m_imm;
  logic       m_isel, m_nsel;

  task automatic model_reset();
    ph = -1; len = 0; m_illegal = 1'b0;
    m_r1 = '0; m_r2 = '0; m_wr = '0; m_op = '0; m_imm = '0; m_isel = 1'b0; m_nsel = 1'b0;
  endtask

  task automatic model_step(input bit r, input bit v, input logic [31:0] ins);
    logic [7:0] op;
    if (r) begin
      model_reset();
    end else if (ph < 0) begin
      if (v) begin
        op = ins[31:24];
        ph = 0;
        if (op <= 8'h05) begin
          m_illegal = 1'b0;
          m_r1   = ins[10:8];
          m_r2   = ins[2:0];
          m_wr   = ins[18:16];
          m_imm  = ins[7:0];
          m_isel = (op == 8'h00);
          m_nsel = (op == 8'h03);
          case (op)
            8'h02, 8'h03: m_op = 3'b001;
            8'h04:        m_op = 3'b010;
            8'h05:        m_op = 3'b011;
            default:      m_op = 3'b000;
          endcase
          len = ((op == 8'h02) || (op == 8'h03)) ? AddW + 3 : LogicW + 3;
        end else begin
          m_illegal = 1'b1;
          len = 1;
        end
      end
    end else begin
      ph++;
      if (ph >= len) ph = -1;
    end
  endtask

  task automatic compare_all(input string tag, input bit r);
    check({tag, ".ready"}, 32'(INSTR_READY), 32'((ph < 0) && !r));
    check({tag, ".busy"},  32'(BUSY),        32'(ph >= 0));
    check({tag, ".we"},    32'(WRITEENABLE), 32'((ph >= 0) && !m_illegal && (ph == len - 1)));
    check({tag, ".ill"},   32'(ILLEGAL),     32'((ph == 0) && m_illegal));
    check({tag, ".rr1"},   32'(READREG1),    32'(m_r1));
    check({tag, ".rr2"},   32'(READREG2),    32'(m_r2));
    check({tag, ".wr"},    32'(WRITEREG),    32'(m_wr));
    check({tag, ".aluop"}, 32'(ALUOP),       32'(m_op));
    check({tag, ".imm"},   32'(IMMEDIATE),   32'(m_imm));
    check({tag, ".isel"},  32'(IMM_SEL),     32'(m_isel));
    check({tag, ".nsel"},  32'(NEG_SEL),     32'(m_nsel));
  endtask

  task automatic cycle(input string tag, input bit r, input bit v, input logic [31:0] ins);
    @(negedge CLK);
    RESET       = r;
    INSTR_VALID = v;
    INSTRUCTION = ins;
    if (r) begin
      model_reset();
      #1 compare_all({tag, ".async"}, 1'b1);
    end
    @(posedge CLK);
    model_step(r, v, ins);
    #1 compare_all(tag, r);
  endtask

  task automatic idle(input string tag, input int n);
    for (int i = 0; i < n; i++) cycle(tag, 1'b0, 1'b0, 32'h0);
  endtask

  int we_cnt;
  int we_first;

  initial begin
    logic [31:0] ins;
    bit          r, v;
    model_reset();
    #1 compare_all("por", 1'b1);
    cycle("rst", 1'b1, 1'b0, 32'h0);
    cycle("rst", 1'b1, 1'b0, 32'h0);

    // loadi: write strobe exactly once, three cycles after acceptance
    cycle("loadi", 1'b0, 1'b1, 32'h0002_002A);
    we_cnt = 0; we_first = -1;
    for (int i = 1; i <= 6; i++) begin
      cycle("loadi", 1'b0, 1'b0, 32'h0);
      if (WRITEENABLE) begin
        we_cnt++;
        if (we_first < 0) we_first = i;
      end
    end
    check("loadi.we_count", 32'(we_cnt), 32'd1);
    check("loadi.we_delay", 32'(we_first), 32'd3);

    cycle("add", 1'b0, 1'b1, 32'h0203_0102);
    idle("add", 6);

    // sub with valid held high through BUSY: the following or is taken only once idle
    cycle("sub", 1'b0, 1'b1, 32'h0304_0102);
    for (int i = 0; i < 8; i++) cycle("sub_hold", 1'b0, 1'b1, 32'h0501_0203);
    idle("sub", 6);

    cycle("illegal", 1'b0, 1'b1, 32'h0700_0000);
    idle("illegal", 3);

    // reset in EXEC of an add, then back-to-back and / or
    cycle("rst_mid", 1'b0, 1'b1, 32'h0205_0304);
    idle("rst_mid", 2);
    cycle("rst_mid", 1'b1, 1'b1, 32'h0205_0304);
    cycle("and", 1'b0, 1'b1, 32'h0406_0501);
    for (int i = 0; i < 6; i++) cycle("or", 1'b0, 1'b1, 32'h0507_0602);
    idle("or", 6);

    // upper register-field bits are ignored
    cycle("regfield", 1'b0, 1'b1, 32'h01FA_FAFA);
    idle("regfield", 5);
    cycle("regfield_li", 1'b0, 1'b1, 32'h00FA_FAFA);
    idle("regfield_li", 5);

    for (int i = 0; i < 600; i++) begin
      r   = ($urandom_range(0, 79) == 0);
      v   = $urandom_range(0, 1) == 1;
      ins = $urandom;
      if ($urandom_range(0, 9) < 7) ins[31:24] = 8'($urandom_range(0, 5));
      cycle("rand", r, v, ins);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
